avalon_st_packet_gen: RTL and testbench

AVALON_ST_PACKET_GEN -- requirements
Module: avalon_st_packet_gen

---
 rtl/avalon_st_packet_gen_if.sv | 16 +
 rtl/avalon_st_packet_gen.sv | 144 ++++++++++++++
 tb/tb_avalon_st_packet_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_st_packet_gen_if.sv
// Avalon-ST source/sink bundle: data, valid, sop, eop and empty from the source,
// with rdy returned by the sink (readyLatency 0).
interface avalon_st_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1
);
    logic [DATA_WIDTH-1:0]  data;
    logic                   valid;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
    logic                   rdy;

    modport master (output data, valid, sop, eop, empty, input rdy);
    modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_packet_gen.sv
// Avalon-ST packet generator: emits ceil(len/bytes) beats of seed+k with sop/eop/empty.
// Define PKT_GEN_BUBBLE_EN to insert one idle cycle after every accepted non-eop beat.
module avalon_st_packet_gen #(
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           pkt_len_bytes,
    input  logic [DATA_WIDTH-1:0] seed,
    avalon_st_if.master           gen_out,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  len_err,
    output logic                  start_ignored,
    output logic [15:0]           pkt_count
);
    localparam int BYTES = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("DATA_WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic {IDLE, SENDING} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  seed_q, seed_d;
    logic [15:0]            beat_idx_q, beat_idx_d;
    logic [15:0]            last_idx_q, last_idx_d;
    logic [EMPTY_WIDTH-1:0] empty_q, empty_d;
    logic                   valid_q, valid_d;
    logic                   pkt_done_q, pkt_done_d;
    logic                   len_err_q, len_err_d;
    logic                   start_ignored_q, start_ignored_d;
    logic [15:0]            pkt_count_q, pkt_count_d;

    logic [16:0] beats_calc;
    logic [15:0] len_rem;
    logic        last_beat;
    logic        xfer;

    // Last beat index and eop empty count are precomputed at start so the
    // beat path only needs an equality compare.
    always_comb begin
        beats_calc = (17'(pkt_len_bytes) + 17'(BYTES - 1)) / 17'(BYTES);
        len_rem    = pkt_len_bytes % 16'(BYTES);
        last_beat  = (beat_idx_q == last_idx_q);
        xfer       = valid_q & gen_out.rdy;
    end

    always_comb begin
        state_d         = state_q;
        seed_d          = seed_q;
        beat_idx_d      = beat_idx_q;
        last_idx_d      = last_idx_q;
        empty_d         = empty_q;
        valid_d         = valid_q;
        pkt_done_d      = 1'b0;
        len_err_d       = 1'b0;
        start_ignored_d = 1'b0;
        pkt_count_d     = pkt_count_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    if (pkt_len_bytes == 16'd0) begin
                        len_err_d = 1'b1;
                    end else begin
                        state_d    = SENDING;
                        seed_d     = seed;
                        beat_idx_d = 16'd0;
                        last_idx_d = 16'(beats_calc - 17'd1);
                        empty_d    = (len_rem == 16'd0) ? '0
                                                        : EMPTY_WIDTH'(16'(BYTES) - len_rem);
                        valid_d    = 1'b1;
                    end
                end
            end
            SENDING: begin
                // Any start here, including one coincident with the eop beat, is dropped.
                start_ignored_d = start;
                if (xfer) begin
                    if (last_beat) begin
                        state_d     = IDLE;
                        valid_d     = 1'b0;
                        pkt_done_d  = 1'b1;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end else begin
                        beat_idx_d = beat_idx_q + 16'd1;
`ifdef PKT_GEN_BUBBLE_EN
                        valid_d    = 1'b0;
`else
                        valid_d    = 1'b1;
`endif
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            seed_q          <= '0;
            beat_idx_q      <= '0;
            last_idx_q      <= '0;
            empty_q         <= '0;
            valid_q         <= 1'b0;
            pkt_done_q      <= 1'b0;
            len_err_q       <= 1'b0;
            start_ignored_q <= 1'b0;
            pkt_count_q     <= '0;
        end else begin
            state_q         <= state_d;
            seed_q          <= seed_d;
            beat_idx_q      <= beat_idx_d;
            last_idx_q      <= last_idx_d;
            empty_q         <= empty_d;
            valid_q         <= valid_d;
            pkt_done_q      <= pkt_done_d;
            len_err_q       <= len_err_d;
            start_ignored_q <= start_ignored_d;
            pkt_count_q     <= pkt_count_d;
        end
    end

    // Payload fields are forced to zero whenever no beat is presented.
    assign gen_out.valid = valid_q;
    assign gen_out.data  = valid_q ? (seed_q + DATA_WIDTH'(beat_idx_q)) : '0;
    assign gen_out.sop   = valid_q & (beat_idx_q == 16'd0);
    assign gen_out.eop   = valid_q & last_beat;
    assign gen_out.empty = (valid_q & last_beat) ? empty_q : '0;

    assign busy          = (state_q == SENDING);
    assign pkt_done      = pkt_done_q;
    assign len_err       = len_err_q;
    assign start_ignored = start_ignored_q;
    assign pkt_count     = pkt_count_q;
endmodule

// File: tb/tb_avalon_st_packet_gen.sv
// Scoreboard bench for avalon_st_packet_gen (DATA_WIDTH=32); expected beats are queued
// when a start is accepted and compared as the sink accepts each beat.
module tb_avalon_st_packet_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pkt_len_bytes = 16'd0;
    logic [31:0] seed = 32'd0;
    logic        busy, pkt_done, len_err, start_ignored;
    logic [15:0] pkt_count;

    avalon_st_if #(.DATA_WIDTH(32), .EMPTY_WIDTH(2)) gen_if ();

    avalon_st_packet_gen #(.DATA_WIDTH(32), .EMPTY_WIDTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pkt_len_bytes (pkt_len_bytes),
        .seed          (seed),
        .gen_out       (gen_if.master),
        .busy          (busy),
        .pkt_done      (pkt_done),
        .len_err       (len_err),
        .start_ignored (start_ignored),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    beat_t       exp_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    bit          mon_en = 1'b0;
    bit          exp_busy = 1'b0;
    bit          exp_done = 1'b0;
    bit          exp_len_err = 1'b0;
    bit          exp_ign = 1'b0;
    logic [15:0] exp_count = 16'd0;
    bit          stall_pend = 1'b0;
    beat_t       held;
    bit          next_pend = 1'b0;
    logic        next_valid_exp = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            beat_t got;
            beat_t e;
            bit    eop_xfer;
            int    nb;
            got = {gen_if.data, gen_if.sop, gen_if.eop, gen_if.empty};

            check("busy", 64'(busy), 64'(exp_busy));
            check("pkt_done", 64'(pkt_done), 64'(exp_done));
            check("len_err", 64'(len_err), 64'(exp_len_err));
            check("start_ignored", 64'(start_ignored), 64'(exp_ign));
            check("pkt_count", 64'(pkt_count), 64'(exp_count));
            if (!gen_if.valid) check("idle_zero", 64'(got), 64'd0);
            if (!exp_busy) check("valid_idle", 64'(gen_if.valid), 64'd0);
            if (stall_pend) begin
                check("stall_valid", 64'(gen_if.valid), 64'd1);
                check("stall_hold", 64'(got), 64'(held));
            end
            if (next_pend) check("valid_next", 64'(gen_if.valid), 64'(next_valid_exp));

            stall_pend  = 1'b0;
            next_pend   = 1'b0;
            exp_done    = 1'b0;
            exp_len_err = 1'b0;
            exp_ign     = 1'b0;
            eop_xfer    = 1'b0;

            if (rst) begin
                exp_busy  = 1'b0;
                exp_count = 16'd0;
                exp_q.delete();
            end else begin
                if (gen_if.valid && gen_if.rdy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("beat data=%08h sop=%0d eop=%0d empty=%0d", got.data, got.sop, got.eop, got.empty);
                        check("beat", 64'(got), 64'(e));
                        if (e.eop) begin
                            eop_xfer  = 1'b1;
                            exp_done  = 1'b1;
                            exp_count = exp_count + 16'd1;
                        end else begin
                            next_pend = 1'b1;
`ifdef PKT_GEN_BUBBLE_EN
                            next_valid_exp = 1'b0;
`else
                            next_valid_exp = 1'b1;
`endif
                        end
                    end
                end else if (gen_if.valid) begin
                    stall_pend = 1'b1;
                    held       = got;
                end
                if (start) begin
                    if (exp_busy) begin
                        exp_ign = 1'b1;
                    end else if (pkt_len_bytes == 16'd0) begin
                        exp_len_err = 1'b1;
                    end else begin
                        nb = (int'(pkt_len_bytes) + 3) / 4;
                        for (int k = 0; k < nb; k++) begin
                            e.data  = seed + 32'(k);
                            e.sop   = (k == 0);
                            e.eop   = (k == nb - 1);
                            e.empty = (k == nb - 1) ? 2'(nb * 4 - int'(pkt_len_bytes)) : 2'd0;
                            exp_q.push_back(e);
                        end
                        next_pend      = 1'b1;
                        next_valid_exp = 1'b1;
                        exp_busy       = 1'b1;
                    end
                end
                if (eop_xfer) exp_busy = 1'b0;
            end
        end
    end

    task automatic start_pkt(input logic [15:0] len, input logic [31:0] sd);
        @(posedge clk); #1;
        start = 1'b1;
        pkt_len_bytes = len;
        seed = sd;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(posedge clk);
            if (!exp_busy && exp_q.size() == 0) done = 1'b1;
        end
        #1;
        if (!done) check("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        gen_if.rdy = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        // start during reset must be discarded
        start = 1'b1; pkt_len_bytes = 16'd8; seed = 32'h5;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        rst = 1'b0;

        start_pkt(16'd8, 32'h10);
        wait_idle();
        start_pkt(16'd5, 32'hA0);
        wait_idle();
        start_pkt(16'd3, 32'h55);
        wait_idle();
        start_pkt(16'd1, 32'hFFFF_FFFF);
        wait_idle();
        start_pkt(16'd9, 32'hFFFF_FFFE);
        wait_idle();

        // 12-byte packet with rdy low for 3 cycles while beat 1 is presented
        start_pkt(16'd12, 32'h0);
        @(posedge clk); #1;
        gen_if.rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        gen_if.rdy = 1'b1;
        wait_idle();

        // start while busy is ignored, then zero length while idle
        start_pkt(16'd16, 32'h100);
        start_pkt(16'd4, 32'hDEAD);
        wait_idle();
        start_pkt(16'd0, 32'h1234);
        wait_idle();

        // start coincident with eop transfer is ignored; the next one is taken
        start_pkt(16'd4, 32'h77);
        start = 1'b1; pkt_len_bytes = 16'd6; seed = 32'h99;
        @(posedge clk); #1;
        pkt_len_bytes = 16'd8; seed = 32'h88;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // reset while beat 1 of a 4-beat packet is presented
        start_pkt(16'd16, 32'h40);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle();
        start_pkt(16'd7, 32'h300);
        wait_idle();

        // random lengths, random sink backpressure, stray starts
        for (int p = 0; p < 20; p++) begin
            start_pkt(16'($urandom_range(1, 40)), $urandom);
            for (int c = 0; c < 400 && (exp_busy || exp_q.size() != 0); c++) begin
                @(posedge clk); #1;
                gen_if.rdy = 1'($urandom_range(0, 1));
                start = ($urandom_range(0, 7) == 0);
                pkt_len_bytes = 16'($urandom_range(0, 8));
                seed = $urandom;
            end
            start = 1'b0;
            gen_if.rdy = 1'b1;
            wait_idle();
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
